ex: RTL
=======

Name: ex

Overview:
- Execute stage. Consumes the ID/EX pipeline register outputs and produces the write-back data, destination and enable for the EX/MEM register.
- Single-cycle ALU for RV32I ops; resolves branches and jumps and raises the IF/ID and ID/EX flush.
- Contains an iterative RV32M multiply/divide unit that holds the pipeline through the ctrl stall request.

Parameters:
- MULDIV_EN, 1, 1 = RV32M ops execute iteratively; 0 = M ops yield 0 with no stall.
- ITER, 32, shift/subtract iterations per M op (equals the operand width).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (`ResetEnable = 1'b0)
- stall  in  6  ctrl stall vector; bit 3 = EX held by a downstream request
- ex_reg1  in  32  operand 1
- ex_reg2  in  32  operand 2 (ID has already muxed in Imm for I-type ALU ops)
- ex_Imm  in  32  branch/jump offset
- ex_rd  in  5  destination register
- ex_rd_enable  in  1  write enable
- ex_alu_op  in  `ALU_Len  ALU/M opcode
- ex_jump_op  in  `Jump_Len  NoJump/JAL/JALR
- ex_branch_op  in  `Branch_Len  NoBranch/BEQ..BGEU
- ex_jump_addr1  in  `AddrLen  instruction PC
- mem_rd_data  out  32  result
- mem_rd  out  5  destination
- mem_rd_enable  out  1  write enable
- jump_flag  out  1  redirect fetch
- jump_target  out  `AddrLen  redirect PC
- idex_clear  out  1  flush ID/EX and IF/ID
- ex_stall_req  out  1  to ctrl; ctrl asserts stall[3:0] while this is high

Behaviour:
- Reset (rst = 0, asynchronous): FSM goes to IDLE, counter = 0, accumulators = 0, ex_stall_req = 0. All outputs are combinational from the inputs and the FSM; with ID/EX reset (NoAlu/NoJump/NoBranch) every output is 0.
- ALU ops (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI pass-through):
  - Combinational, latency 0.
  - Shifts use reg2[4:0]; arithmetic wraps modulo 2^32.
  - mem_rd / mem_rd_enable pass ex_rd / ex_rd_enable.
- JAL:
  - rd_data = PC + 4; jump_target = PC + Imm.
  - jump_flag = 1, idex_clear = 1.
- JALR:
  - rd_data = PC + 4; jump_target = (reg1 + Imm) & ~1.
  - jump_flag = 1, idex_clear = 1.
- Branches:
  - Compare reg1 and reg2; signed compare for BLT/BGE, unsigned for BLTU/BGEU.
  - Taken: jump_flag = 1, jump_target = PC + Imm, idex_clear = 1.
  - mem_rd_enable = 0 whether taken or not.
- jump_flag and idex_clear are forced to 0 while stall[3] = 1, so a held instruction cannot redirect twice.
- M-unit FSM, states IDLE, CALC, DONE:
  - IDLE, M op present: latch |reg1|, |reg2|, result sign, op class; counter = 0; ex_stall_req = 1; next state CALC.
  - IDLE, divide by zero: next state DONE directly. DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - IDLE, DIV/REM of 0x80000000 by -1: next state DONE directly. Quotient 0x80000000, remainder 0.
  - CALC: one shift-add (MUL*) or restoring subtract (DIV*/REM*) step per cycle. ex_stall_req = 1. After counter = ITER-1, next state DONE.
  - DONE: ex_stall_req = 0; mem_rd_data = sign-corrected result (low or high word as the op selects); mem_rd_enable = ex_rd_enable. Next state IDLE on the first edge with stall[3] = 0; otherwise hold DONE.
  - While in IDLE with an M op, or in CALC: mem_rd_enable = 0.
  - Latency: 34 cycles from op arrival to DONE; 33 of them stalled. Special cases take 2 cycles, 1 stalled.
- Inputs are held stable by ID/EX while stalled; the unit never re-samples the operands in CALC or DONE.
- Asynchronous reset mid-CALC aborts the op and returns to IDLE; no write-back is produced.

Decomposition:
- Shared config.vh additions:
  - ALU opcode constants, including MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Jump and branch opcodes.
  - ResetEnable = 1'b0.
  - ZERO_WORD.
- One sub-module, muldiv_unit:
  - Contains the FSM, counter and accumulators.
  - Interface: start, op, a, b → busy, done, result.
  - ex instantiates it, gated by MULDIV_EN.

Test Plan:
- ADD reg1 = 5, reg2 = 0xFFFFFFFF, rd = 3 → same cycle: mem_rd_data = 4, mem_rd = 3, mem_rd_enable = 1, jump_flag = 0.
- BLT reg1 = 0xFFFFFFFF, reg2 = 1, PC = 0x100, Imm = 0x20 → jump_flag = 1, jump_target = 0x120, idex_clear = 1, mem_rd_enable = 0. Repeat as BLTU → not taken.
- JALR PC = 0x40, reg1 = 0x1001, Imm = 2 → jump_target = 0x1002, mem_rd_data = 0x44.
- MULH reg1 = 0x80000000, reg2 = 2 → ex_stall_req high for exactly 33 cycles; DONE gives 0xFFFFFFFF with mem_rd_enable = 1.
- DIV reg1 = 7, reg2 = 0 → one stall cycle, result 0xFFFFFFFF. REM reg1 = 0x80000000, reg2 = 0xFFFFFFFF → result 0.
- DIVU 100/7 with rst pulsed low at CALC count 10 → FSM IDLE immediately, ex_stall_req = 0. Reissue → quotient 14; a stall[3] pulse held in DONE keeps 14 on mem_rd_data.

Source files
------------

// File: rtl/ex_pkg.sv
// Execute-stage shared definitions: widths, opcodes, M-unit states and reset level.
package ex_pkg;

    localparam int DATA_LEN = 32;
    localparam int ADDR_LEN = 32;
    localparam int RD_LEN   = 5;

    localparam logic                RESET_ENABLE = 1'b0;
    localparam logic [DATA_LEN-1:0] ZERO_WORD    = '0;

    // ALU and RV32M opcodes as decoded by ID.
    typedef enum logic [4:0] {
        ALU_NOP,
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_LUI,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_t;

    typedef enum logic [1:0] {
        JMP_NONE,
        JMP_JAL,
        JMP_JALR
    } jump_op_t;

    typedef enum logic [2:0] {
        BR_NONE,
        BR_BEQ,
        BR_BNE,
        BR_BLT,
        BR_BGE,
        BR_BLTU,
        BR_BGEU
    } branch_op_t;

    // Multiply/divide unit sequencing.
    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_DONE
    } md_state_t;

    // True for every opcode handled by the iterative multiply/divide unit.
    function automatic logic is_mop(input alu_op_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/ex_if.sv
// ID/EX -> EX -> EX/MEM bus of the execute stage, plus the ctrl stall handshake.
// Stall handshake: EX raises ex_stall_req while it needs the current ID/EX
// contents held; ctrl answers by asserting stall[3:0], and bit 3 set means
// EX must neither redirect nor advance its M-unit out of DONE.
interface ex_if;
    import ex_pkg::*;

    logic [5:0]          stall;
    logic [DATA_LEN-1:0] ex_reg1;
    logic [DATA_LEN-1:0] ex_reg2;
    logic [DATA_LEN-1:0] ex_Imm;
    logic [RD_LEN-1:0]   ex_rd;
    logic                ex_rd_enable;
    alu_op_t             ex_alu_op;
    jump_op_t            ex_jump_op;
    branch_op_t          ex_branch_op;
    logic [ADDR_LEN-1:0] ex_jump_addr1;

    logic [DATA_LEN-1:0] mem_rd_data;
    logic [RD_LEN-1:0]   mem_rd;
    logic                mem_rd_enable;
    logic                jump_flag;
    logic [ADDR_LEN-1:0] jump_target;
    logic                idex_clear;
    logic                ex_stall_req;
    md_state_t           dbg_md_state;

    modport master (
        output stall, ex_reg1, ex_reg2, ex_Imm, ex_rd, ex_rd_enable,
               ex_alu_op, ex_jump_op, ex_branch_op, ex_jump_addr1,
        input  mem_rd_data, mem_rd, mem_rd_enable, jump_flag, jump_target,
               idex_clear, ex_stall_req, dbg_md_state
    );

    modport slave (
        input  stall, ex_reg1, ex_reg2, ex_Imm, ex_rd, ex_rd_enable,
               ex_alu_op, ex_jump_op, ex_branch_op, ex_jump_addr1,
        output mem_rd_data, mem_rd, mem_rd_enable, jump_flag, jump_target,
               idex_clear, ex_stall_req, dbg_md_state
    );

endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M unit: shift-add multiply and restoring divide, one bit per cycle.
// hi/lo accumulators are shared: multiply builds {hi,lo} as the 64-bit product,
// divide keeps the partial remainder in hi and shifts the quotient into lo.
module ex_muldiv_unit
    import ex_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  alu_op_t             i_op,
    input  logic [DATA_LEN-1:0] i_a,
    input  logic [DATA_LEN-1:0] i_b,
    input  logic                i_hold,
    output logic                o_busy,
    output logic                o_done,
    output logic [DATA_LEN-1:0] o_result,
    output md_state_t           o_state
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_t           r_state;
    md_state_t           w_next;
    logic [CW-1:0]       r_cnt;
    logic [DATA_LEN-1:0] r_hi;
    logic [DATA_LEN-1:0] r_lo;
    logic [DATA_LEN-1:0] r_b;
    logic                r_neg;
    logic                r_neg_r;
    alu_op_t             r_op;

    logic                w_a_neg;
    logic                w_b_neg;
    logic [DATA_LEN-1:0] w_a_abs;
    logic [DATA_LEN-1:0] w_b_abs;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic                w_r_is_div;
    logic [32:0]         w_msum;
    logic [32:0]         w_rshift;
    logic [33:0]         w_diff;
    logic [63:0]         w_prod;
    logic [DATA_LEN-1:0] w_res;

    // Operand decode on the arriving op: magnitudes, signs and the two early-out cases.
    always_comb begin
        w_a_neg    = (i_op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM}) && i_a[31];
        w_b_neg    = (i_op inside {ALU_MULH, ALU_DIV, ALU_REM}) && i_b[31];
        w_a_abs    = w_a_neg ? (~i_a + 32'd1) : i_a;
        w_b_abs    = w_b_neg ? (~i_b + 32'd1) : i_b;
        w_div_zero = (i_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) && (i_b == ZERO_WORD);
        w_div_ovf  = (i_op inside {ALU_DIV, ALU_REM}) && (i_a == 32'h8000_0000) &&
                     (i_b == 32'hFFFF_FFFF);
    end

    // One iteration of either algorithm, computed from the held accumulators.
    always_comb begin
        w_r_is_div = r_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        w_msum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
        w_rshift   = {r_hi, r_lo[31]};
        w_diff     = {1'b0, w_rshift} - {2'b00, r_b};
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RESET_ENABLE) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and stall request; DONE waits for the pipeline to release EX.
    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (i_start) begin
                    o_busy = 1'b1;
                    w_next = (w_div_zero || w_div_ovf) ? MD_DONE : MD_CALC;
                end
            end
            MD_CALC: begin
                o_busy = 1'b1;
                if (r_cnt == CW'(ITER - 1)) begin
                    w_next = MD_DONE;
                end
            end
            MD_DONE: begin
                if (!i_hold) begin
                    w_next = MD_IDLE;
                end
            end
            default: w_next = MD_IDLE;
        endcase
        if (rst == RESET_ENABLE) begin
            o_busy = 1'b0;
        end
    end

    // Operand latch on start, then one shift-add or restoring-subtract step per CALC cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RESET_ENABLE) begin
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_neg   <= 1'b0;
            r_neg_r <= 1'b0;
            r_op    <= ALU_NOP;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (i_start) begin
                        r_op  <= i_op;
                        r_cnt <= '0;
                        if (w_div_zero) begin
                            r_lo    <= 32'hFFFF_FFFF;
                            r_hi    <= i_a;
                            r_b     <= '0;
                            r_neg   <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else if (w_div_ovf) begin
                            r_lo    <= 32'h8000_0000;
                            r_hi    <= '0;
                            r_b     <= '0;
                            r_neg   <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            r_lo    <= w_a_abs;
                            r_hi    <= '0;
                            r_b     <= w_b_abs;
                            r_neg   <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end
                    end
                end
                MD_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_r_is_div) begin
                        if (!w_diff[33]) begin
                            r_hi <= w_diff[31:0];
                            r_lo <= {r_lo[30:0], 1'b1};
                        end else begin
                            r_hi <= w_rshift[31:0];
                            r_lo <= {r_lo[30:0], 1'b0};
                        end
                    end else begin
                        r_hi <= w_msum[32:1];
                        r_lo <= {w_msum[0], r_lo[31:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Sign correction and word select of the finished result.
    always_comb begin
        w_prod = r_neg ? (~{r_hi, r_lo} + 64'd1) : {r_hi, r_lo};
        case (r_op)
            ALU_MUL:                           w_res = w_prod[31:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:   w_res = w_prod[63:32];
            ALU_DIV, ALU_DIVU:                 w_res = r_neg ? (~r_lo + 32'd1) : r_lo;
            ALU_REM, ALU_REMU:                 w_res = r_neg_r ? (~r_hi + 32'd1) : r_hi;
            default:                           w_res = ZERO_WORD;
        endcase
        o_done   = (r_state == MD_DONE);
        o_result = o_done ? w_res : ZERO_WORD;
        o_state  = r_state;
    end

endmodule

// File: rtl/ex.sv
// Execute stage: single-cycle RV32I ALU, branch/jump resolution, iterative RV32M unit.
module ex
    import ex_pkg::*;
#(
    parameter int MULDIV_EN = 1,
    parameter int ITER      = 32
) (
    input  logic clk,
    input  logic rst,
    ex_if.slave  bus
);

    logic [DATA_LEN-1:0] w_reg1;
    logic [DATA_LEN-1:0] w_reg2;
    logic [4:0]          w_shamt;
    logic [DATA_LEN-1:0] w_alu_res;
    logic [ADDR_LEN-1:0] w_pc_plus4;
    logic [ADDR_LEN-1:0] w_pc_imm;
    logic [ADDR_LEN-1:0] w_jalr_tgt;
    logic                w_br_taken;
    logic                w_hold;
    logic                w_is_mop;
    logic                w_md_busy;
    logic                w_md_done;
    logic [DATA_LEN-1:0] w_md_result;
    md_state_t           w_md_state;
    logic [DATA_LEN-1:0] w_rd_data;
    logic                w_rd_en;
    logic                w_jflag;
    logic [ADDR_LEN-1:0] w_jtgt;
    logic                w_unused;

    assign w_reg1     = bus.ex_reg1;
    assign w_reg2     = bus.ex_reg2;
    assign w_shamt    = bus.ex_reg2[4:0];
    assign w_hold     = bus.stall[3];
    assign w_is_mop   = (MULDIV_EN != 0) && is_mop(bus.ex_alu_op);
    assign w_pc_plus4 = bus.ex_jump_addr1 + 32'd4;
    assign w_pc_imm   = bus.ex_jump_addr1 + bus.ex_Imm;
    assign w_jalr_tgt = (w_reg1 + bus.ex_Imm) & ~32'd1;
    assign w_unused   = &{1'b0, bus.stall[5:4], bus.stall[2:0]};

    // RV32I arithmetic/logic result; M ops and NOP contribute zero here.
    always_comb begin
        w_alu_res = ZERO_WORD;
        case (bus.ex_alu_op)
            ALU_ADD:  w_alu_res = w_reg1 + w_reg2;
            ALU_SUB:  w_alu_res = w_reg1 - w_reg2;
            ALU_SLL:  w_alu_res = w_reg1 << w_shamt;
            ALU_SLT:  w_alu_res = {31'd0, $signed(w_reg1) < $signed(w_reg2)};
            ALU_SLTU: w_alu_res = {31'd0, w_reg1 < w_reg2};
            ALU_XOR:  w_alu_res = w_reg1 ^ w_reg2;
            ALU_SRL:  w_alu_res = w_reg1 >> w_shamt;
            ALU_SRA:  w_alu_res = $unsigned($signed(w_reg1) >>> w_shamt);
            ALU_OR:   w_alu_res = w_reg1 | w_reg2;
            ALU_AND:  w_alu_res = w_reg1 & w_reg2;
            ALU_LUI:  w_alu_res = w_reg2;
            default:  w_alu_res = ZERO_WORD;
        endcase
    end

    // Branch condition: signed for BLT/BGE, unsigned for BLTU/BGEU.
    always_comb begin
        w_br_taken = 1'b0;
        case (bus.ex_branch_op)
            BR_BEQ:  w_br_taken = (w_reg1 == w_reg2);
            BR_BNE:  w_br_taken = (w_reg1 != w_reg2);
            BR_BLT:  w_br_taken = ($signed(w_reg1) <  $signed(w_reg2));
            BR_BGE:  w_br_taken = ($signed(w_reg1) >= $signed(w_reg2));
            BR_BLTU: w_br_taken = (w_reg1 <  w_reg2);
            BR_BGEU: w_br_taken = (w_reg1 >= w_reg2);
            default: w_br_taken = 1'b0;
        endcase
    end

    generate
        if (MULDIV_EN != 0) begin : g_muldiv
            ex_muldiv_unit #(
                .ITER (ITER)
            ) u_muldiv (
                .clk      (clk),
                .rst      (rst),
                .i_start  (w_is_mop),
                .i_op     (bus.ex_alu_op),
                .i_a      (w_reg1),
                .i_b      (w_reg2),
                .i_hold   (w_hold),
                .o_busy   (w_md_busy),
                .o_done   (w_md_done),
                .o_result (w_md_result),
                .o_state  (w_md_state)
            );
        end else begin : g_no_muldiv
            assign w_md_busy   = 1'b0;
            assign w_md_done   = 1'b0;
            assign w_md_result = ZERO_WORD;
            assign w_md_state  = MD_IDLE;
        end
    endgenerate

    // Write-back and redirect selection; an M op only writes back once DONE.
    always_comb begin
        w_rd_data = w_alu_res;
        w_rd_en   = bus.ex_rd_enable;
        w_jflag   = 1'b0;
        w_jtgt    = ZERO_WORD;
        if (bus.ex_jump_op == JMP_JAL) begin
            w_rd_data = w_pc_plus4;
            w_jflag   = 1'b1;
            w_jtgt    = w_pc_imm;
        end else if (bus.ex_jump_op == JMP_JALR) begin
            w_rd_data = w_pc_plus4;
            w_jflag   = 1'b1;
            w_jtgt    = w_jalr_tgt;
        end else if (bus.ex_branch_op != BR_NONE) begin
            w_rd_data = ZERO_WORD;
            w_rd_en   = 1'b0;
            w_jflag   = w_br_taken;
            w_jtgt    = w_br_taken ? w_pc_imm : ZERO_WORD;
        end else if (w_is_mop) begin
            w_rd_data = w_md_result;
            w_rd_en   = w_md_done & bus.ex_rd_enable;
        end
    end

    // A held instruction must not redirect fetch a second time.
    assign bus.jump_flag     = w_jflag & ~w_hold;
    assign bus.idex_clear    = w_jflag & ~w_hold;
    assign bus.jump_target   = w_jtgt;
    assign bus.mem_rd_data   = w_rd_data;
    assign bus.mem_rd        = bus.ex_rd;
    assign bus.mem_rd_enable = w_rd_en;
    assign bus.ex_stall_req  = w_md_busy;
    assign bus.dbg_md_state  = w_md_state;

endmodule
